// File: rtl/shape_pkg.sv
// Types and helpers shared by the voice scheduling path.
`include "constants.svh"

package shape_pkg;

  typedef enum logic [2:0] {
    SCHED_IDLE   = 3'd0,
    SCHED_ISSUE  = 3'd1,
    SCHED_WAIT   = 3'd2,
    SCHED_SCALE  = 3'd3,
    SCHED_OUTPUT = 3'd4
  } sched_state_t;

  localparam int GAIN_WIDTH     = 8;
  localparam int GAIN_FRAC_BITS = 7;

  // Accumulator headroom: one extra bit per doubling of the voice count,
  // so summing every voice at full scale can never wrap.
  function automatic int acc_width(input int sample_w, input int n_voices);
    return sample_w + $clog2(n_voices);
  endfunction

endpackage

// File: rtl/constants.svh
// Audio-path constants shared across the synth voice blocks.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`define SAMPLE_WIDTH  24
`define GAIN_UNITY    8'h80
`define N_OSCILLATORS 8

`endif

// File: rtl/voice_scheduler_sat_scale.sv
// Signed value times unsigned fixed-point gain, rescaled and clamped to the output range.
module sat_scale #(
  parameter int IN_W      = 27,
  parameter int GAIN_W    = 8,
  parameter int FRAC_BITS = GAIN_W - 1,
  parameter int OUT_W     = 24
) (
  input  logic signed [IN_W-1:0]   value,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [OUT_W-1:0]  result
);

  // One spare bit so the zero-extended gain stays positive as a signed operand.
  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam logic signed [PROD_W-1:0] OUT_MAX =
    {{(PROD_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [PROD_W-1:0] value_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] shifted;

  always_comb begin
    value_ext = PROD_W'(value);
    gain_ext  = PROD_W'(gain);
    product   = value_ext * gain_ext;
    shifted   = product >>> FRAC_BITS;
    if (shifted > OUT_MAX) begin
      result = OUT_MAX[OUT_W-1:0];
    end else if (shifted < OUT_MIN) begin
      result = OUT_MIN[OUT_W-1:0];
    end else begin
      result = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Walks the enabled voices through the shared oscillator core once per sample
// tick, mixes and scales the results, and hands one sample to the DAC path.
`include "constants.svh"

module voice_scheduler
  import shape_pkg::*;
#(
  parameter int N_VOICES = `N_OSCILLATORS,
  parameter int WIDTH    = `SAMPLE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        sample_tick,
  input  logic [N_VOICES-1:0]         voice_enable,
  input  logic [7:0]                  volume,
  output logic                        osc_req_valid,
  output logic [$clog2(N_VOICES)-1:0] osc_req_idx,
  input  logic                        osc_resp_valid,
  input  logic [WIDTH-1:0]            osc_resp_data,
  output logic [WIDTH-1:0]            sample_out,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  localparam int IDX_W = $clog2(N_VOICES);
  localparam int ACC_W = acc_width(WIDTH, N_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

  localparam logic [2:0] IDLE   = SCHED_IDLE;
  localparam logic [2:0] ISSUE  = SCHED_ISSUE;
  localparam logic [2:0] WAIT   = SCHED_WAIT;
  localparam logic [2:0] SCALE  = SCHED_SCALE;
  localparam logic [2:0] OUTPUT = SCHED_OUTPUT;

  logic [2:0]              state;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [WIDTH-1:0] scaled;
  logic                    voice_on;
  logic                    last_voice;
  logic                    handshake;
  logic                    tick_drop;

  // A tick is only welcome in IDLE or on the cycle the DAC takes the sample.
  always_comb begin
    voice_on   = voice_enable[idx];
    last_voice = (idx == LAST_IDX);
    handshake  = (state == OUTPUT) && sample_ready;
    tick_drop  = sample_tick && (state != IDLE) && !handshake;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_tick) begin
            acc   <= '0;
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (voice_on) begin
            state <= WAIT;
          end else if (last_voice) begin
            state <= SCALE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        WAIT: begin
          if (osc_resp_valid) begin
            acc <= acc + ACC_W'($signed(osc_resp_data));
            if (last_voice) begin
              state <= SCALE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ISSUE;
            end
          end
        end
        SCALE: begin
          state <= OUTPUT;
        end
        OUTPUT: begin
          if (sample_ready) begin
            if (sample_tick) begin
              acc   <= '0;
              idx   <= '0;
              state <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sat_scale #(
    .IN_W      (ACC_W),
    .GAIN_W    (GAIN_WIDTH),
    .FRAC_BITS (GAIN_FRAC_BITS),
    .OUT_W     (WIDTH)
  ) u_sat_scale (
    .value  (acc),
    .gain   (volume),
    .result (scaled)
  );

  // sample_out only changes in SCALE, so it holds through OUTPUT and beyond.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_out <= '0;
    end else if (state == SCALE) begin
      sample_out <= scaled;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (tick_drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  always_comb begin
    osc_req_valid = (state == ISSUE) && voice_on;
    osc_req_idx   = idx;
    sample_valid  = (state == OUTPUT);
    busy          = (state != IDLE);
  end

endmodule
